// File: rtl/d_to_sr_encoder_if.sv
// rtl/d_to_sr_encoder_if.sv - D-bit input stream, SR command outputs and flop feedback check signals
interface d_to_sr_encoder_if #(
  parameter int CNT_W = 8
);
  logic             d_in;
  logic             d_valid;
  logic             d_ready;
  logic             s;
  logic             r;
  logic             q_exp;
  logic             q_fb;
  logic             mismatch;
  logic [CNT_W-1:0] err_cnt;
  logic             clear_err;

  modport master (
    output d_in, d_valid, q_fb, clear_err,
    input  d_ready, s, r, q_exp, mismatch, err_cnt
  );

  modport slave (
    input  d_in, d_valid, q_fb, clear_err,
    output d_ready, s, r, q_exp, mismatch, err_cnt
  );
endinterface

// File: rtl/d_to_sr_encoder.sv
// rtl/d_to_sr_encoder.sv - encodes a D-bit stream into set/reset pulses and checks the fed-back flop state
module d_to_sr_encoder #(
  parameter int DEPTH   = 4,
  parameter int CNT_W   = 8,
  parameter int CHK_DLY = 1
) (
  input logic              clk,
  input logic              rst_n,
  d_to_sr_encoder_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL     = DEPTH[AW:0];
  localparam logic [AW:0] CNT_ONE  = {{AW{1'b0}}, 1'b1};

  logic [DEPTH-1:0] mem;
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             push;
  logic             pop;
  logic             b;
  logic             q_exp_next;
  logic             armed_next;
  logic             hit;
  logic             s_q;
  logic             r_q;
  logic             q_exp_q;
  logic             armed;
  logic             mismatch_q;
  logic [CNT_W-1:0] err_cnt_q;
  logic [CHK_DLY:0] dl_q;
  logic [CHK_DLY:0] dl_armed;

  assign bus.d_ready  = (count < FULL);
  assign push         = bus.d_valid && bus.d_ready;
  assign pop          = (count != '0);
  assign b            = mem[rd_ptr];
  assign q_exp_next   = pop ? b : q_exp_q;
  assign armed_next   = armed | pop;
  // Delay line is loaded with the post-pop state, so its last stage lines up with edge k+2+CHK_DLY.
  assign hit          = dl_armed[CHK_DLY] && (bus.q_fb != dl_q[CHK_DLY]);

  assign bus.s        = s_q;
  assign bus.r        = r_q;
  assign bus.q_exp    = q_exp_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem        <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      s_q        <= 1'b0;
      r_q        <= 1'b0;
      q_exp_q    <= 1'b0;
      armed      <= 1'b0;
      dl_q       <= '0;
      dl_armed   <= '0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= bus.d_in;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase

      // s and r are mutually exclusive by construction: each needs q_exp_q at the opposite polarity.
      s_q     <= pop & b & ~q_exp_q;
      r_q     <= pop & ~b & q_exp_q;
      q_exp_q <= q_exp_next;
      armed   <= armed_next;

      dl_q[0]     <= q_exp_next;
      dl_armed[0] <= armed_next;
      for (int i = 1; i <= CHK_DLY; i++) begin
        dl_q[i]     <= dl_q[i-1];
        dl_armed[i] <= dl_armed[i-1];
      end

      mismatch_q <= hit;
      if (bus.clear_err) begin
        err_cnt_q <= '0;
      end else if (hit && (err_cnt_q != {CNT_W{1'b1}})) begin
        err_cnt_q <= err_cnt_q + CNT_W'(1);
      end
    end
  end
endmodule
